// File: rtl/dnn_accel_system_nios2_qsys_0_oci_dct_packer.sv
// OCI debug-trace packer: collects 2-bit trace symbols into 30-bit frames,
// hands them to the test-bench consumer over a valid/ready handshake, and
// sequences end-of-test (flush the partial frame, drain the output slot).
module dnn_accel_system_nios2_qsys_0_oci_dct_packer #(
    parameter int SYM_W      = 2,
    parameter int FRAME_SYMS = 15
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        trc_valid,
    input  logic [SYM_W-1:0]            trc_sym,
    input  logic                        test_end_req,
    input  logic                        out_ready,
    output logic [SYM_W*FRAME_SYMS-1:0] dct_buffer,
    output logic [3:0]                  dct_count,
    output logic                        dct_valid,
    output logic                        test_ending,
    output logic                        test_has_ended,
    output logic                        overflow
);

    localparam int FRAME_W = SYM_W * FRAME_SYMS;
    localparam logic [3:0] FULL = 4'(FRAME_SYMS);
    localparam logic [3:0] LAST = 4'(FRAME_SYMS - 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e             state;
    logic [FRAME_W-1:0] acc;
    logic [3:0]         acc_count;

    logic               slot_free;
    logic               accept;
    logic [FRAME_W-1:0] acc_appended;

    // Handshake qualifiers and the accumulator with the incoming symbol
    // dropped into the next free slot (upper slots are kept at zero).
    always_comb begin
        slot_free    = !dct_valid || out_ready;
        accept       = trc_valid && (state == RUN);
        acc_appended = acc;
        for (int i = 0; i < FRAME_SYMS; i++) begin
            if (acc_count == 4'(i)) begin
                acc_appended[SYM_W*i +: SYM_W] = trc_sym;
            end
        end
    end

    // Accumulation, output slot and end-of-test sequencing in one register block.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= RUN;
            acc            <= '0;
            acc_count      <= '0;
            dct_buffer     <= '0;
            dct_count      <= '0;
            dct_valid      <= 1'b0;
            test_ending    <= 1'b0;
            test_has_ended <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            // A consumed frame leaves the slot empty unless something reloads it below.
            if (dct_valid && out_ready) begin
                dct_valid <= 1'b0;
            end

            if (acc_count == FULL && slot_free) begin
                // A full accumulator moves out first; a new symbol restarts it.
                dct_buffer <= acc;
                dct_count  <= FULL;
                dct_valid  <= 1'b1;
                acc        <= '0;
                if (accept) begin
                    acc[SYM_W-1:0] <= trc_sym;
                    acc_count      <= 4'd1;
                end else begin
                    acc_count <= 4'd0;
                end
            end else if (accept && acc_count == LAST && slot_free) begin
                // The 15th symbol completes the frame and goes straight out.
                dct_buffer <= {trc_sym, acc[FRAME_W-SYM_W-1:0]};
                dct_count  <= FULL;
                dct_valid  <= 1'b1;
                acc        <= '0;
                acc_count  <= 4'd0;
            end else if (accept && acc_count != FULL) begin
                acc       <= acc_appended;
                acc_count <= acc_count + 4'd1;
            end else if (accept) begin
                // Accumulator full and output slot occupied: nowhere to keep it.
                overflow <= 1'b1;
            end

            case (state)
                RUN: begin
                    if (test_end_req) begin
                        state       <= FLUSH;
                        test_ending <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (acc_count == 4'd0) begin
                        state <= DRAIN;
                    end else if (slot_free) begin
                        dct_buffer <= acc;
                        dct_count  <= acc_count;
                        dct_valid  <= 1'b1;
                        acc        <= '0;
                        acc_count  <= 4'd0;
                        state      <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!dct_valid || out_ready) begin
                        state          <= DONE;
                        test_ending    <= 1'b0;
                        test_has_ended <= 1'b1;
                    end
                end
                DONE: begin
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dnn_accel_system_nios2_qsys_0_oci_dct_packer.sv
// Self-checking bench for the OCI trace packer: directed scenarios plus a
// randomized run, all checked against a queue-based reference model.
module tb_dnn_accel_system_nios2_qsys_0_oci_dct_packer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        trc_valid = 1'b0;
    logic [1:0]  trc_sym = 2'd0;
    logic        test_end_req = 1'b0;
    logic        out_ready = 1'b0;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        dct_valid;
    logic        test_ending;
    logic        test_has_ended;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    dnn_accel_system_nios2_qsys_0_oci_dct_packer dut (
        .clk            (clk),
        .reset          (reset),
        .trc_valid      (trc_valid),
        .trc_sym        (trc_sym),
        .test_end_req   (test_end_req),
        .out_ready      (out_ready),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .dct_valid      (dct_valid),
        .test_ending    (test_ending),
        .test_has_ended (test_has_ended),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    // Reference model: pending symbols in a queue, one output slot.
    typedef enum {M_RUN, M_FLUSH, M_DRAIN, M_DONE} m_state_e;
    logic [1:0]  acc_q[$];
    m_state_e    m_state;
    logic        m_valid, m_ovf, m_ending, m_ended;
    logic [29:0] m_buf;
    logic [3:0]  m_cnt;

    function automatic logic [29:0] pack(input logic [1:0] q[$]);
        logic [29:0] r = '0;
        for (int i = 0; i < q.size(); i++) r = r | (30'(q[i]) << (2 * i));
        return r;
    endfunction

    task automatic model_reset();
        acc_q.delete();
        m_state = M_RUN;
        m_valid = 0; m_ovf = 0; m_ending = 0; m_ended = 0;
        m_buf = '0; m_cnt = '0;
    endtask

    task automatic emit();
        m_buf   = pack(acc_q);
        m_cnt   = 4'(acc_q.size());
        m_valid = 1;
        acc_q.delete();
    endtask

    task automatic model_step();
        int   pre_size  = acc_q.size();
        logic pre_valid = m_valid;
        logic slot_free = !m_valid || out_ready;
        logic accept    = trc_valid && (m_state == M_RUN);
        if (m_valid && out_ready) m_valid = 0;
        if (pre_size == 15 && slot_free) begin
            emit();
            if (accept) acc_q.push_back(trc_sym);
        end else if (accept) begin
            if (pre_size < 15) begin
                acc_q.push_back(trc_sym);
                if (acc_q.size() == 15 && slot_free) emit();
            end else begin
                m_ovf = 1;
            end
        end
        case (m_state)
            M_RUN:   if (test_end_req) begin m_state = M_FLUSH; m_ending = 1; end
            M_FLUSH: begin
                if (pre_size == 0) m_state = M_DRAIN;
                else if (slot_free) begin
                    if (acc_q.size() > 0) emit();
                    m_state = M_DRAIN;
                end
            end
            M_DRAIN: if (!pre_valid || out_ready) begin m_state = M_DONE; m_ending = 0; m_ended = 1; end
            default: ;
        endcase
    endtask

    // Apply one cycle of inputs, advance the model at the edge, return at the falling edge.
    task automatic step(input logic v, input logic [1:0] s, input logic rdy, input logic endr);
        trc_valid = v; trc_sym = s; out_ready = rdy; test_end_req = endr;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        trc_valid = 0; test_end_req = 0; out_ready = 0; trc_sym = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({dct_valid, dct_count, dct_buffer} !== {1'b0, 4'd0, 30'd0}) begin
            bad++; $display("[TB] FAIL reset_frame got v=%0b c=%0d b=%h want 0/0/0", dct_valid, dct_count, dct_buffer);
        end
        total++;
        if ({test_ending, test_has_ended, overflow} !== 3'b000) begin
            bad++; $display("[TB] FAIL reset_flags got %b%b%b want 000", test_ending, test_has_ended, overflow);
        end
    endtask

    task automatic test_full_frame();
        logic [29:0] exp_buf = '0;
        for (int i = 0; i < 15; i++) begin
            exp_buf = exp_buf | (30'(i % 4) << (2 * i));
            step(1, 2'(i % 4), 1, 0);
            if (i < 14) begin
                total++;
                if (dct_valid !== 1'b0) begin
                    bad++; $display("[TB] FAIL full_early_valid sym=%0d got %0b want 0", i, dct_valid);
                end
            end
        end
        total++;
        if ({dct_valid, dct_count, dct_buffer} !== {1'b1, 4'd15, exp_buf}) begin
            bad++; $display("[TB] FAIL full_frame got v=%0b c=%0d b=%h want 1/15/%h", dct_valid, dct_count, dct_buffer, exp_buf);
        end
        total++;
        if (dct_buffer[29:28] !== 2'd2) begin
            bad++; $display("[TB] FAIL full_top_sym got %0d want 2", dct_buffer[29:28]);
        end
        step(0, 0, 1, 0);
        total++;
        if (dct_valid !== 1'b0) begin
            bad++; $display("[TB] FAIL full_drop_valid got %0b want 0", dct_valid);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 31; i++) begin
            step(1, 2'd3, 0, 0);
            if (i == 14) begin
                total++;
                if ({dct_valid, dct_count, dct_buffer, overflow} !== {1'b1, 4'd15, 30'h3FFFFFFF, 1'b0}) begin
                    bad++; $display("[TB] FAIL bp_held got v=%0b c=%0d b=%h o=%0b", dct_valid, dct_count, dct_buffer, overflow);
                end
            end
            if (i == 29) begin
                total++;
                if (overflow !== 1'b0) begin
                    bad++; $display("[TB] FAIL bp_early_ovf got %0b want 0", overflow);
                end
            end
        end
        total++;
        if (overflow !== 1'b1) begin
            bad++; $display("[TB] FAIL bp_ovf got %0b want 1", overflow);
        end
        step(0, 0, 1, 0);
        total++;
        if ({dct_valid, dct_count, dct_buffer, overflow} !== {1'b1, 4'd15, 30'h3FFFFFFF, 1'b1}) begin
            bad++; $display("[TB] FAIL bp_second got v=%0b c=%0d b=%h o=%0b", dct_valid, dct_count, dct_buffer, overflow);
        end
        step(0, 0, 1, 0);
        total++;
        if (dct_valid !== 1'b0) begin
            bad++; $display("[TB] FAIL bp_release got %0b want 0", dct_valid);
        end
    endtask

    task automatic test_partial_flush();
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 2'd2, 1, 0);
        step(0, 0, 1, 1);
        total++;
        if ({test_ending, test_has_ended, dct_valid} !== 3'b100) begin
            bad++; $display("[TB] FAIL pf_ending got e=%0b d=%0b v=%0b want 1/0/0", test_ending, test_has_ended, dct_valid);
        end
        step(0, 0, 0, 0);
        total++;
        if ({dct_valid, dct_count, dct_buffer} !== {1'b1, 4'd5, 30'h000002AA}) begin
            bad++; $display("[TB] FAIL pf_frame got v=%0b c=%0d b=%h want 1/5/000002aa", dct_valid, dct_count, dct_buffer);
        end
        step(0, 0, 1, 0);
        total++;
        if ({test_ending, test_has_ended, dct_valid} !== 3'b010) begin
            bad++; $display("[TB] FAIL pf_done got e=%0b d=%0b v=%0b want 0/1/0", test_ending, test_has_ended, dct_valid);
        end
    endtask

    task automatic test_empty_flush();
        logic [2:0] exp_flags [3] = '{3'b100, 3'b100, 3'b010};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, (i == 0));
            total++;
            if ({test_ending, test_has_ended, dct_valid} !== exp_flags[i]) begin
                bad++; $display("[TB] FAIL ef_edge%0d got e/d/v=%b want %b", i, {test_ending, test_has_ended, dct_valid}, exp_flags[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  syms[$];
        logic [1:0]  s;
        logic [29:0] exp_buf;
        do_reset();
        for (int i = 0; i < 15; i++) step(1, 2'($urandom), 0, 0);
        for (int i = 0; i < 15; i++) begin
            s = 2'($urandom);
            syms.push_back(s);
            step(1, s, (i == 14), 0);
        end
        exp_buf = pack(syms);
        total++;
        if ({dct_valid, dct_count, dct_buffer, overflow} !== {1'b1, 4'd15, exp_buf, 1'b0}) begin
            bad++; $display("[TB] FAIL b2b_frame got v=%0b c=%0d b=%h o=%0b want 1/15/%h/0", dct_valid, dct_count, dct_buffer, overflow, exp_buf);
        end
        syms.delete();
        for (int i = 0; i < 4; i++) begin
            s = 2'($urandom);
            syms.push_back(s);
            step(1, s, 1, (i == 3));
        end
        step(0, 0, 1, 0);
        exp_buf = pack(syms);
        total++;
        if ({dct_valid, dct_count, dct_buffer} !== {1'b1, 4'd4, exp_buf}) begin
            bad++; $display("[TB] FAIL b2b_flush got v=%0b c=%0d b=%h want 1/4/%h", dct_valid, dct_count, dct_buffer, exp_buf);
        end
        step(0, 0, 1, 0);
        total++;
        if ({test_has_ended, dct_valid} !== 2'b10) begin
            bad++; $display("[TB] FAIL b2b_done got d=%0b v=%0b want 1/0", test_has_ended, dct_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] syms[$];
        logic [1:0] s;
        do_reset();
        for (int i = 0; i < 22; i++) step(1, 2'($urandom), 0, 0);
        #2 reset = 1'b1;
        #1;
        total++;
        if ({dct_valid, dct_count, dct_buffer, test_ending, test_has_ended, overflow} !== 39'd0) begin
            bad++; $display("[TB] FAIL mid_reset got v=%0b c=%0d b=%h", dct_valid, dct_count, dct_buffer);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 15; i++) begin
            s = 2'($urandom);
            syms.push_back(s);
            step(1, s, 1, 0);
        end
        total++;
        if ({dct_valid, dct_count, dct_buffer} !== {1'b1, 4'd15, pack(syms)}) begin
            bad++; $display("[TB] FAIL mid_fresh got v=%0b c=%0d b=%h want 1/15/%h", dct_valid, dct_count, dct_buffer, pack(syms));
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            step(($urandom % 4) != 0, 2'($urandom), ($urandom % 3) != 0, ($urandom % 150) == 0);
            total++;
            if ({dct_valid, dct_count, dct_buffer, overflow, test_ending, test_has_ended} !==
                {m_valid, m_cnt, m_buf, m_ovf, m_ending, m_ended}) begin
                bad++;
                $display("[TB] FAIL random cyc=%0d got v=%0b c=%0d b=%h o=%0b e=%0b d=%0b want v=%0b c=%0d b=%h o=%0b e=%0b d=%0b",
                         cyc, dct_valid, dct_count, dct_buffer, overflow, test_ending, test_has_ended,
                         m_valid, m_cnt, m_buf, m_ovf, m_ending, m_ended);
            end
            if (m_state == M_DONE) do_reset();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_full_frame();
        test_backpressure();
        test_partial_flush();
        test_empty_flush();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
